// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard controller.
// The pipeline side (master) drives the ID/EX hazard inputs; the controller side (slave) returns the strobes.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_md_start;
  logic             ex_branch_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_hold;
  logic             exmem_bubble;
  logic             bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_memread, ex_md_start, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold,
           exmem_bubble, bubble, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_memread, ex_md_start, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold,
           exmem_bubble, bubble, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use stalls, multi-cycle
// mul/div occupancy of EX, and wrong-path flushes on taken branches.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_if.slave   hz
);

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_e;

  localparam logic [3:0]       MdInit   = 4'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic             bubble_q, bubble_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble;

  // A load into x0 never creates a real dependency, so it is excluded.
  assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                     (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      bubble_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      bubble_q    <= bubble_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;

    case (state_q)
      RUN: begin
        // A taken branch wins: the ID/IF instructions are wrong-path, so their hazards are moot.
        if (hz.ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hz.ex_md_start) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
          md_cnt_d     = MdInit;
          state_d      = MD_WAIT;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end

      MD_WAIT: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_hold    = 1'b1;
        exmem_bubble = 1'b1;
        if (md_cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    bubble_d    = idex_bubble;
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  always_comb begin
    assert (!(idex_bubble && idex_hold));
    assert (!ifid_flush || pc_write);
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.idex_hold    = idex_hold;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.bubble       = bubble_q;
  assign hz.md_busy      = (state_q == MD_WAIT);
  assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by random
// traffic, compared cycle by cycle against an occupancy-based reference model.
module tb_hazard_ctrl;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // Model state: cycles of EX occupancy still owed by a mul/div, the bubble sitting in EX, stalls seen.
  int mdLeft;
  bit bubbleM;
  int stallM;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic bit refLoadUse(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic u1, input logic u2,
                                    input logic [4:0] rd, input logic mr);
    bit dep;
    dep = 0;
    if (mr && rd != 0) begin
      if (u1 && rd == rs1) dep = 1;
      if (u2 && rd == rs2) dep = 1;
    end
    return dep;
  endfunction

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr,
                               input logic ms, input logic br, input logic rn);
    bit ePc, eIfid, eFlush, eBub, eHold, eExb, eBusy;
    @(negedge clk);
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.id_use_rs1      = u1;
    hz.id_use_rs2      = u2;
    hz.ex_rd           = rd;
    hz.ex_memread      = mr;
    hz.ex_md_start     = ms;
    hz.ex_branch_taken = br;
    rst_n              = rn;
    #1;
    ePc = 1; eIfid = 1; eFlush = 0; eBub = 0; eHold = 0; eExb = 0;
    eBusy = (mdLeft > 0);
    if (mdLeft > 0) begin
      ePc = 0; eIfid = 0; eHold = 1; eExb = 1;
    end else if (br) begin
      eFlush = 1; eBub = 1;
    end else if (ms) begin
      ePc = 0; eIfid = 0; eHold = 1; eExb = 1;
    end else if (refLoadUse(rs1, rs2, u1, u2, rd, mr)) begin
      ePc = 0; eIfid = 0; eBub = 1;
    end
    checkOutput("pc_write",     int'(hz.pc_write),     int'(ePc));
    checkOutput("ifid_write",   int'(hz.ifid_write),   int'(eIfid));
    checkOutput("ifid_flush",   int'(hz.ifid_flush),   int'(eFlush));
    checkOutput("idex_bubble",  int'(hz.idex_bubble),  int'(eBub));
    checkOutput("idex_hold",    int'(hz.idex_hold),    int'(eHold));
    checkOutput("exmem_bubble", int'(hz.exmem_bubble), int'(eExb));
    checkOutput("bubble",       int'(hz.bubble),       int'(bubbleM));
    checkOutput("md_busy",      int'(hz.md_busy),      int'(eBusy));
    checkOutput("stall_cnt",    int'(hz.stall_cnt),    stallM);
    @(posedge clk);
    if (!rn) begin
      mdLeft  = 0;
      bubbleM = 0;
      stallM  = 0;
    end else begin
      if (mdLeft > 0) mdLeft--;
      else if (!br && ms) mdLeft = MD_LATENCY - 1;
      bubbleM = eBub;
      if (!ePc && stallM < CNT_MAX) stallM++;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    mdLeft     = 0;
    bubbleM    = 0;
    stallM     = 0;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.ex_rd = '0; hz.ex_memread = 0; hz.ex_md_start = 0; hz.ex_branch_taken = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] reset state and load-use");
    idleCycle();
    applyStimulus(5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCycle();
    idleCycle();

    $display("[TB] load to x0 and unused operand");
    applyStimulus(5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd8, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] mul/div occupancy");
    applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) idleCycle();

    $display("[TB] branch beats mul/div and load-use");
    applyStimulus(5'd6, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    idleCycle();

    $display("[TB] reset during mul/div wait");
    applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    idleCycle();
    applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    idleCycle();

    $display("[TB] stall counter saturation");
    repeat (20) applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) applyStimulus(5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCycle();

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 39) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core. It sits beside the forwarding unit. It detects load-use hazards in ID and sequences multi-cycle mul/div occupancy of EX. It also issues flushes on taken branches resolved in EX. It drives PC/IF-ID write enables, pipeline bubble/flush strobes and the `bubble` input consumed by the forwarding unit.

Parameters:
MD_LATENCY, 4, total EX cycles of a mul/div op (legal range 2..15)
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX
ex_memread  in  1  EX instruction is a load
ex_md_start  in  1  EX holds a mul/div in its first EX cycle
ex_branch_taken  in  1  branch/jump in EX resolved taken
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  zero IF/ID this edge
idex_bubble  out  1  load NOP into ID/EX this edge
idex_hold  out  1  hold ID/EX contents (EX occupied)
exmem_bubble  out  1  load NOP into EX/MEM this edge
bubble  out  1  registered: bubble present in EX this cycle (to forwarding)
md_busy  out  1  FSM in MD_WAIT
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Single clock, clk. Reset is synchronous, active-low, on rst_n.
- FSM states: RUN, MD_WAIT. A down-counter md_cnt (4 bits) is used in MD_WAIT.
- Reset (rst_n=0 at a rising edge) sets: state=RUN, md_cnt=0, bubble=0, stall_cnt=0.
  - Outputs after reset are pure RUN defaults with no hazard: pc_write=1, ifid_write=1, all flush/bubble/hold strobes 0, md_busy=0.
  - Reset mid-MD_WAIT aborts the wait immediately.
- load_use (combinational) = ex_memread & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- RUN, priority order highest first:
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. ex_md_start and load_use are ignored because the ID/IF instructions are wrong-path. Next bubble=1. Stay RUN.
  2. ex_md_start: pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1. md_cnt<=MD_LATENCY-2. Go MD_WAIT.
  3. load_use: pc_write=0, ifid_write=0, idex_bubble=1. Next bubble=1. Stay RUN. Exactly one stall cycle results, because the next cycle has a NOP in EX so load_use cannot reassert.
  4. Otherwise: defaults, next bubble=0.
- MD_WAIT:
  - pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1, md_busy=1.
  - load_use and ex_branch_taken are ignored, because EX holds the mul/div.
  - If md_cnt==0, go RUN and the mul/div result advances to EX/MEM on that exit edge. Otherwise md_cnt decrements.
  - Total EX occupancy = MD_LATENCY cycles: the start cycle plus MD_LATENCY-1 in MD_WAIT.
  - ex_md_start may remain high during MD_WAIT; it is ignored.
- bubble register: set on any edge where idex_bubble=1; cleared otherwise. It holds 0 during MD_WAIT.
- stall_cnt increments on every edge where pc_write=0 and saturates at all-ones (no wrap).
- All outputs except bubble, md_busy and stall_cnt are combinational from state and inputs. Latency from a hazard input to its strobe is zero cycles.
- Strobe invariants:
  - Never idex_bubble & idex_hold simultaneously.
  - ifid_flush implies pc_write=1.

Test Plan:
- Load-use: EX lw x5 (ex_memread=1, ex_rd=5), ID add reads rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle bubble=1, no stall. stall_cnt=1.
- Load to x0 / unused operand: ex_rd=0 with id_rs1=0, or ex_rd=7 with id_rs2=7 and id_use_rs2=0 -> no stall, all defaults.
- Mul/div with MD_LATENCY=4: ex_md_start pulse -> pc_write=0 for exactly 4 consecutive cycles, md_busy=1 for 3 cycles, back to RUN. stall_cnt=4.
- Simultaneous ex_branch_taken=1, ex_md_start=1 and load_use -> ifid_flush=1, idex_bubble=1, pc_write=1, state stays RUN, stall_cnt unchanged.
- rst_n=0 during the 2nd MD_WAIT cycle -> next edge state=RUN, md_busy=0, stall_cnt=0, pc_write=1.
- Saturation with CNT_W=4: 20 consecutive load-use/mul-div stall cycles -> stall_cnt holds at 15.
